// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Imported by shift_step_unit and shift_sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int MAX_STEP = 2;

  // Bits that one step discards off the top are safe only if uniform.
  function automatic logic top_mixed(input logic [2:0] top,
                                     input logic [1:0] step);
    logic mixed;
    mixed = 1'b0;
    unique case (step)
      2'd2:    mixed = !((&top) || !(|top));
      2'd1:    mixed = top[2] ^ top[1];
      default: mixed = 1'b0;
    endcase
    return mixed;
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single step of the shift sequencer: shifts by 0, 1 or 2.
// SRA fills from sign_i so the original operand sign is preserved.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  shift_op_e        op_i,
  input  logic [1:0]       step_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = value_i;
    unique case (1'b1)
      step_i == 2'd1: begin
        unique case (op_i)
          SHIFT_SLL: result_o = {value_i[WIDTH-2:0], 1'b0};
          SHIFT_SRL: result_o = {1'b0, value_i[WIDTH-1:1]};
          SHIFT_SRA: result_o = {sign_i, value_i[WIDTH-1:1]};
          SHIFT_ROL: result_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
          default:   result_o = value_i;
        endcase
      end
      step_i == 2'd2: begin
        unique case (op_i)
          SHIFT_SLL: result_o = {value_i[WIDTH-3:0], 2'b00};
          SHIFT_SRL: result_o = {2'b00, value_i[WIDTH-1:2]};
          SHIFT_SRA: result_o = {{2{sign_i}}, value_i[WIDTH-1:2]};
          SHIFT_ROL: result_o = {value_i[WIDTH-3:0], value_i[WIDTH-1:WIDTH-2]};
          default:   result_o = value_i;
        endcase
      end
      default: result_o = value_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: up to two bit positions per cycle, start/resultRDY handshake.
// Define SHIFT_OVF_EN to report SLL signed overflow on data_exception.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [1:0]         ctrl_op,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] data_shamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               data_exception,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  shift_op_e          op_q, op_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               rdy_q, rdy_d;
  logic               exc_q, exc_d;

  logic [1:0]         step;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   shifted;
  logic               step_ovf;

  always_comb begin
    step = 2'd0;
    unique case (1'b1)
      rem_q >= SHAMT_W'(MAX_STEP): step = 2'd2;
      rem_q == SHAMT_W'(1):        step = 2'd1;
      default:                     step = 2'd0;
    endcase
  end

  assign rem_next = rem_q - SHAMT_W'(step);

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .value_i (work_q),
    .op_i    (op_q),
    .step_i  (step),
    .sign_i  (sign_q),
    .result_o(shifted)
  );

`ifdef SHIFT_OVF_EN
  assign step_ovf = (op_q == SHIFT_SLL) &&
                    top_mixed(work_q[WIDTH-1 -: 3], step);
`else
  assign step_ovf = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    exc_d    = exc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_start) begin
          work_d  = data_operand;
          rem_d   = data_shamt;
          op_d    = shift_op_e'(ctrl_op);
          sign_d  = data_operand[WIDTH-1];
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_next;
        ovf_d  = ovf_q | step_ovf;
        // Completion is decided on the same edge that consumes the last bits.
        if (rem_next == '0) begin
          state_d  = DONE;
          result_d = shifted;
          rdy_d    = 1'b1;
          exc_d    = ovf_q | step_ovf;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= SHIFT_SLL;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign data_exception = exc_q;
  assign busy           = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed vector bench for shift_sequencer.
// Expected exception values follow SHIFT_OVF_EN when it is defined.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [1:0]  ctrl_op;
  logic [31:0] data_operand;
  logic [4:0]  data_shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SHIFT_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  shift_sequencer #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_start    (ctrl_start),
    .ctrl_op       (ctrl_op),
    .data_operand  (data_operand),
    .data_shamt    (data_shamt),
    .data_result   (data_result),
    .data_resultRDY(data_resultRDY),
    .data_exception(data_exception),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
    int          exp_edges;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] opnd,
                        input logic [4:0] sh, output int edges);
    @(negedge clock);
    ctrl_start   = 1'b1;
    ctrl_op      = op;
    data_operand = opnd;
    data_shamt   = sh;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    edges = 0;
    while (edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
      if (data_resultRDY) break;
    end
    if (!data_resultRDY) begin
      n_chk++;
      n_fail++;
      $display("FAIL rdy_timeout: actual=no_pulse required=pulse");
    end
  endtask

  int edges;
  int rdy_cnt;

  initial begin
    vecs[0]  = '{SLL, 32'h00000001, 5'd5,  32'h00000020, 3,  1'b0};
    vecs[1]  = '{SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 16, 1'b0};
    vecs[2]  = '{SRL, 32'h80000000, 5'd31, 32'h00000001, 16, 1'b0};
    vecs[3]  = '{ROL, 32'h80000001, 5'd1,  32'h00000003, 1,  1'b0};
    vecs[4]  = '{SRL, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1,  1'b0};
    vecs[5]  = '{SLL, 32'h40000000, 5'd1,  32'h80000000, 1,  1'b1};
    vecs[6]  = '{SLL, 32'hC0000000, 5'd1,  32'h80000000, 1,  1'b0};
    vecs[7]  = '{ROL, 32'h12345678, 5'd4,  32'h23456781, 2,  1'b0};
    vecs[8]  = '{SRA, 32'h7FFFFFF0, 5'd3,  32'h0FFFFFFE, 2,  1'b0};
    vecs[9]  = '{SLL, 32'h00000003, 5'd30, 32'hC0000000, 15, 1'b1};
    vecs[10] = '{ROL, 32'h80000001, 5'd31, 32'hC0000000, 16, 1'b0};
    vecs[11] = '{SRA, 32'h80000000, 5'd1,  32'hC0000000, 1,  1'b0};
    vecs[12] = '{SLL, 32'h12345678, 5'd0,  32'h12345678, 1,  1'b0};
    vecs[13] = '{SRL, 32'hF0000000, 5'd7,  32'h01E00000, 4,  1'b0};

    reset        = 1'b1;
    ctrl_start   = 1'b0;
    ctrl_op      = 2'b00;
    data_operand = '0;
    data_shamt   = '0;
    #1;
    chk("reset_result", data_result, 32'h0);
    chk("reset_rdy", 32'(data_resultRDY), 32'd0);
    chk("reset_exc", 32'(data_exception), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].operand, vecs[i].shamt, edges);
      chk($sformatf("v%0d_result", i), data_result, vecs[i].exp_res);
      chk($sformatf("v%0d_edges", i), 32'(edges), 32'(vecs[i].exp_edges));
      chk($sformatf("v%0d_exc", i), 32'(data_exception),
          32'(vecs[i].exp_ovf & OVF_EN));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_rdy_drop", i), 32'(data_resultRDY), 32'd0);
      chk($sformatf("v%0d_hold", i), data_result, vecs[i].exp_res);
    end

    // Starts during SHIFT are ignored; a start in DONE is taken at once.
    @(negedge clock);
    ctrl_start   = 1'b1;
    ctrl_op      = SLL;
    data_operand = 32'h000000FF;
    data_shamt   = 5'd8;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    rdy_cnt    = 0;
    @(posedge clock);
    #1;
    rdy_cnt += int'(data_resultRDY);
    ctrl_start   = 1'b1;
    ctrl_op      = SRL;
    data_operand = 32'hAAAA5555;
    data_shamt   = 5'd0;
    @(posedge clock);
    #1;
    rdy_cnt += int'(data_resultRDY);
    @(posedge clock);
    #1;
    rdy_cnt += int'(data_resultRDY);
    ctrl_start = 1'b0;
    @(posedge clock);
    #1;
    rdy_cnt += int'(data_resultRDY);
    chk("ign_rdy", 32'(data_resultRDY), 32'd1);
    chk("ign_result", data_result, 32'h0000FF00);
    ctrl_start   = 1'b1;
    ctrl_op      = SRL;
    data_operand = 32'h00000100;
    data_shamt   = 5'd2;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_rdy_low", 32'(data_resultRDY), 32'd0);
    @(posedge clock);
    #1;
    chk("b2b_rdy", 32'(data_resultRDY), 32'd1);
    chk("b2b_result", data_result, 32'h00000040);
    @(posedge clock);
    #1;
    chk("b2b_idle_rdy", 32'(data_resultRDY), 32'd0);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_hold", data_result, 32'h00000040);
    chk("ign_rdy_count", 32'(rdy_cnt), 32'd1);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clock);
    ctrl_start   = 1'b1;
    ctrl_op      = SLL;
    data_operand = 32'h00000001;
    data_shamt   = 5'd20;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_result", data_result, 32'h0);
    chk("mid_rst_rdy", 32'(data_resultRDY), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_exc", 32'(data_exception), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rdy_cnt = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      rdy_cnt += int'(data_resultRDY) + int'(busy);
    end
    chk("mid_rst_aborted", 32'(rdy_cnt), 32'd0);
    run_op(SLL, 32'h00000003, 5'd4, edges);
    chk("post_rst_result", data_result, 32'h00000030);
    chk("post_rst_edges", 32'(edges), 32'd2);
    chk("post_rst_exc", 32'(data_exception), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
